pq_cmd_ctrl: RTL and testbench

PQ_CMD_CTRL -- requirements
Module: pq_cmd_ctrl

---
 rtl/pq_cmd_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pq_cmd_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_cmd_ctrl.sv
// Command front-end for a pq_if priority queue: buffers ENQ/DEQ/REPL commands, issues them one at a time, returns in-order responses.
// Define PQ_CMD_STATS_EN to add saturating stat_enq/stat_deq/stat_err counters.
package pq_pkg;
    typedef struct packed {
        logic [7:0] key;
        logic [7:0] value;
    } kv_t;
endpackage

module pq_cmd_ctrl
    import pq_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  kv_t         cmd_kv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output kv_t         rsp_kv,
    output logic        rsp_err,
    output logic        pq_enq,
    output logic        pq_deq,
    output kv_t         pq_kvi,
    input  kv_t         pq_kvo,
    input  logic        pq_full,
    input  logic        pq_empty,
    input  logic        pq_busy
`ifdef PQ_CMD_STATS_EN
    ,
    output logic [15:0] stat_enq,
    output logic [15:0] stat_deq,
    output logic [15:0] stat_err
`endif
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = $clog2(CMD_DEPTH) + 1;

    localparam logic [1:0] OP_ENQ  = 2'b01;
    localparam logic [1:0] OP_DEQ  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        kv_t        kv;
    } cmd_t;

    state_e            state_q, state_d;
    cmd_t              fifoMem_q [CMD_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    kv_t               rspKv_q, rspKv_d;
    logic              rspErr_q, rspErr_d;

    logic              fifoFull, fifoEmpty;
    logic              push, pop;
    logic              moreWork;
    cmd_t              head;

    assign fifoFull  = (count_q == CNT_W'(CMD_DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign cmd_ready = !fifoFull && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifoMem_q[rdPtr_q];
    assign moreWork  = !fifoEmpty || push;

    assign rsp_kv  = rst ? '0 : rspKv_q;
    assign rsp_err = rst ? 1'b0 : rspErr_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {cmd_op, cmd_kv};
        end
    end

    // Entering ISSUE on the accept cycle itself lets a new command strobe on the very next cycle.
    always_comb begin
        state_d   = state_q;
        pq_enq    = 1'b0;
        pq_deq    = 1'b0;
        pq_kvi    = '0;
        pop       = 1'b0;
        rsp_valid = 1'b0;
        rspKv_d   = rspKv_q;
        rspErr_d  = rspErr_q;

        case (state_q)
            IDLE: begin
                if (moreWork) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fifoEmpty) begin
                    state_d = IDLE;
                end else if (!pq_busy) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                    case (head.op)
                        OP_ENQ: begin
                            pq_enq   = !pq_full;
                            pq_kvi   = pq_full ? '0 : head.kv;
                            rspKv_d  = head.kv;
                            rspErr_d = pq_full;
                        end
                        OP_DEQ: begin
                            pq_deq   = !pq_empty;
                            pq_kvi   = pq_empty ? '0 : head.kv;
                            rspKv_d  = pq_empty ? '0 : pq_kvo;
                            rspErr_d = pq_empty;
                        end
                        OP_REPL: begin
                            // A replace keeps occupancy constant, so enq+deq together is legal even when full.
                            pq_deq   = !pq_empty;
                            pq_enq   = !pq_empty || !pq_full;
                            pq_kvi   = (!pq_empty || !pq_full) ? head.kv : '0;
                            rspKv_d  = pq_empty ? '0 : pq_kvo;
                            rspErr_d = 1'b0;
                        end
                        default: begin
                            rspKv_d  = '0;
                            rspErr_d = 1'b0;
                        end
                    endcase
                end
            end
            WAIT: begin
                if (!pq_busy) begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) begin
                        state_d = moreWork ? ISSUE : IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = moreWork ? ISSUE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            pq_enq    = 1'b0;
            pq_deq    = 1'b0;
            pq_kvi    = '0;
            pop       = 1'b0;
            rsp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            rspKv_q  <= '0;
            rspErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rspKv_q  <= rspKv_d;
            rspErr_q <= rspErr_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
        end
    end

`ifdef PQ_CMD_STATS_EN
    logic [15:0] statEnq_q, statDeq_q, statErr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            statEnq_q <= '0;
            statDeq_q <= '0;
            statErr_q <= '0;
        end else begin
            if (pq_enq && statEnq_q != 16'hFFFF) begin
                statEnq_q <= statEnq_q + 16'd1;
            end
            if (pq_deq && statDeq_q != 16'hFFFF) begin
                statDeq_q <= statDeq_q + 16'd1;
            end
            if (rsp_valid && rsp_ready && rspErr_q && statErr_q != 16'hFFFF) begin
                statErr_q <= statErr_q + 16'd1;
            end
        end
    end

    assign stat_enq = statEnq_q;
    assign stat_deq = statDeq_q;
    assign stat_err = statErr_q;
`endif

endmodule

// File: tb/tb_pq_cmd_ctrl.sv
// Bench for pq_cmd_ctrl: behavioural min-priority queue device plus a scoreboard that replays accepted commands on its own queue.
module tb_pq_cmd_ctrl;
    import pq_pkg::*;

    localparam int CMD_DEPTH   = 4;
    localparam int PQ_CAPACITY = 4;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ENQ  = 2'b01;
    localparam logic [1:0] OP_DEQ  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        kv_t        kv;
    } cmdRec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    kv_t        cmd_kv = '0;
    logic       rsp_ready = 1'b0;
    logic       pq_busy = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_err, pq_enq, pq_deq;
    kv_t        rsp_kv, pq_kvi;

    kv_t  devHead = '0;
    logic devFull = 1'b0;
    logic devEmpty = 1'b1;
    kv_t  devQ[$];

    kv_t     refQ[$];
    cmdRec_t pending[$];
    int      acceptLog[$];
    int      rspLog[$];
    int      rspKeyLog[$];
    int      rspErrLog[$];
    int      replPairCount = 0;
    int      cycleCount = 0;
    logic    prevHold = 1'b0;
    kv_t     prevKv = '0;
    logic    prevErr = 1'b0;

    int errorCount = 0;
    int checkCount = 0;

    pq_cmd_ctrl #(.CMD_DEPTH(CMD_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_kv    (cmd_kv),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_kv    (rsp_kv),
        .rsp_err   (rsp_err),
        .pq_enq    (pq_enq),
        .pq_deq    (pq_deq),
        .pq_kvi    (pq_kvi),
        .pq_kvo    (devHead),
        .pq_full   (devFull),
        .pq_empty  (devEmpty),
        .pq_busy   (pq_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic kv_t mkKv(input logic [7:0] k, input logic [7:0] v);
        kv_t r;
        r.key   = k;
        r.value = v;
        return r;
    endfunction

    // Device: min-key queue, ties broken by insertion order; head is visible combinationally as pq_kvo.
    always @(posedge clk) begin
        int idx;
        if (pq_deq && devQ.size() > 0) begin
            idx = 0;
            for (int i = 1; i < devQ.size(); i++) begin
                if (devQ[i].key < devQ[idx].key) idx = i;
            end
            devQ.delete(idx);
        end
        if (pq_enq) devQ.push_back(pq_kvi);
        devEmpty <= (devQ.size() == 0);
        devFull  <= (devQ.size() >= PQ_CAPACITY);
        if (devQ.size() == 0) begin
            devHead <= '0;
        end else begin
            idx = 0;
            for (int i = 1; i < devQ.size(); i++) begin
                if (devQ[i].key < devQ[idx].key) idx = i;
            end
            devHead <= devQ[idx];
        end
    end

    // Monitor: strobe legality, response stability and in-order scoreboard.
    always @(negedge clk) begin
        cmdRec_t    c;
        kv_t        expKv;
        logic       expErr;
        logic [1:0] expStrobe;
        int         idx;
        cycleCount++;
        if (rst) begin
            pending.delete();
            refQ = devQ;
            prevHold = 1'b0;
        end else begin
            if (pq_enq || pq_deq) begin
                checkOutput("enqWhenFull", {31'd0, pq_enq && devFull && !pq_deq}, 0);
                checkOutput("deqWhenEmpty", {31'd0, pq_deq && devEmpty}, 0);
                if (pq_enq && pq_deq) replPairCount++;
                if (pending.size() == 0) begin
                    checkOutput("strobeNoCmd", 1, 0);
                end else begin
                    c = pending[0];
                    case (c.op)
                        OP_ENQ:  expStrobe = {!devFull, 1'b0};
                        OP_DEQ:  expStrobe = {1'b0, !devEmpty};
                        OP_REPL: expStrobe = {!devEmpty || !devFull, !devEmpty};
                        default: expStrobe = 2'b00;
                    endcase
                    checkOutput("strobeKind", {30'd0, pq_enq, pq_deq}, {30'd0, expStrobe});
                    checkOutput("pqKvi", pq_kvi, c.kv);
                end
            end else begin
                checkOutput("pqKviIdle", pq_kvi, 0);
            end

            if (prevHold) begin
                checkOutput("holdValid", rsp_valid, 1);
                checkOutput("holdKv", rsp_kv, prevKv);
                checkOutput("holdErr", rsp_err, prevErr);
            end
            prevHold = rsp_valid && !rsp_ready;
            prevKv   = rsp_kv;
            prevErr  = rsp_err;

            if (rsp_valid && rsp_ready) begin
                rspLog.push_back(cycleCount);
                rspKeyLog.push_back(int'(rsp_kv.key));
                rspErrLog.push_back(int'(rsp_err));
                if (pending.size() == 0) begin
                    checkOutput("rspNoCmd", 1, 0);
                end else begin
                    c = pending.pop_front();
                    expKv = '0;
                    expErr = 1'b0;
                    case (c.op)
                        OP_ENQ: begin
                            expKv = c.kv;
                            if (refQ.size() >= PQ_CAPACITY) expErr = 1'b1;
                            else refQ.push_back(c.kv);
                        end
                        OP_DEQ, OP_REPL: begin
                            if (refQ.size() == 0) begin
                                expErr = (c.op == OP_DEQ);
                            end else begin
                                idx = 0;
                                for (int i = 1; i < refQ.size(); i++) begin
                                    if (refQ[i].key < refQ[idx].key) idx = i;
                                end
                                expKv = refQ[idx];
                                refQ.delete(idx);
                            end
                            if (c.op == OP_REPL) refQ.push_back(c.kv);
                        end
                        default: ;
                    endcase
                    checkOutput("rspKv", rsp_kv, expKv);
                    checkOutput("rspErr", rsp_err, expErr);
                end
            end

            if (cmd_valid && cmd_ready) begin
                pending.push_back('{op: cmd_op, kv: cmd_kv});
                acceptLog.push_back(cycleCount);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input kv_t kv);
        int   n = 0;
        logic accepted = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_kv    = kv;
        do begin
            @(negedge clk);
            accepted = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!accepted && n < 50);
        cmd_valid = 1'b0;
        checkOutput("acceptTimeout", {31'd0, accepted}, 1);
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while ((pending.size() != 0 || rsp_valid) && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainTimeout", pending.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errorCount++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         accBase, rspBase, logBase, pairBase, idx;
        kv_t        stallKv[6];
        logic [1:0] stallOp[6];

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstCmdReady", cmd_ready, 0);
        checkOutput("rstRspValid", rsp_valid, 0);
        checkOutput("rstRspErr", rsp_err, 0);
        checkOutput("rstRspKv", rsp_kv, 0);
        checkOutput("rstPqStrobes", {30'd0, pq_enq, pq_deq}, 0);
        checkOutput("rstPqKvi", pq_kvi, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("cmdReadyAfterRst", cmd_ready, 1);
        checkOutput("noStrobeAfterRst", {30'd0, pq_enq, pq_deq}, 0);
        @(posedge clk);
        #1;

        // Three inserts then three removals come back in key order, one response every two cycles.
        rsp_ready = 1'b1;
        accBase = acceptLog.size();
        rspBase = rspLog.size();
        applyStimulus(OP_ENQ, mkKv(8'd5, 8'h45));
        applyStimulus(OP_ENQ, mkKv(8'd2, 8'h42));
        applyStimulus(OP_ENQ, mkKv(8'd9, 8'h49));
        applyStimulus(OP_DEQ, '0);
        applyStimulus(OP_DEQ, '0);
        applyStimulus(OP_DEQ, '0);
        waitDrain(100);
        checkOutput("rspCount", rspLog.size() - rspBase, 6);
        if (rspLog.size() - rspBase == 6) begin
            checkOutput("firstRspLatency", rspLog[rspBase] - acceptLog[accBase], 2);
            for (int i = 1; i < 6; i++) begin
                checkOutput("rspSpacing", rspLog[rspBase+i] - rspLog[rspBase+i-1], 2);
            end
            checkOutput("echoKey0", rspKeyLog[rspBase], 5);
            checkOutput("echoKey1", rspKeyLog[rspBase+1], 2);
            checkOutput("echoKey2", rspKeyLog[rspBase+2], 9);
            checkOutput("deqKey0", rspKeyLog[rspBase+3], 2);
            checkOutput("deqKey1", rspKeyLog[rspBase+4], 5);
            checkOutput("deqKey2", rspKeyLog[rspBase+5], 9);
        end

        logBase = rspLog.size();
        applyStimulus(OP_DEQ, '0);
        waitDrain(50);
        if (rspLog.size() > logBase) begin
            checkOutput("emptyDeqErr", rspErrLog[logBase], 1);
            checkOutput("emptyDeqKey", rspKeyLog[logBase], 0);
        end else begin
            checkOutput("emptyDeqRsp", 0, 1);
        end

        // Fill the device, overflow with key 7, then replace with key 1.
        logBase  = rspLog.size();
        pairBase = replPairCount;
        for (int k = 10; k < 10 + PQ_CAPACITY; k++) begin
            applyStimulus(OP_ENQ, mkKv(8'(k), 8'h11));
        end
        applyStimulus(OP_ENQ, mkKv(8'd7, 8'h77));
        applyStimulus(OP_REPL, mkKv(8'd1, 8'h01));
        waitDrain(100);
        if (rspLog.size() - logBase == PQ_CAPACITY + 2) begin
            checkOutput("overflowErr", rspErrLog[logBase+PQ_CAPACITY], 1);
            checkOutput("overflowKey", rspKeyLog[logBase+PQ_CAPACITY], 7);
            checkOutput("replErr", rspErrLog[logBase+PQ_CAPACITY+1], 0);
            checkOutput("replKey", rspKeyLog[logBase+PQ_CAPACITY+1], 10);
        end else begin
            checkOutput("fillRspCount", rspLog.size() - logBase, PQ_CAPACITY + 2);
        end
        checkOutput("replPair", replPairCount - pairBase, 1);

        // Stall the response channel while six commands try to enter a four-deep FIFO.
        stallOp = '{OP_ENQ, OP_DEQ, OP_REPL, OP_ENQ, OP_DEQ, OP_ENQ};
        stallKv = '{mkKv(8'd3, 8'h33), '0, mkKv(8'd8, 8'h88), mkKv(8'd4, 8'h44), '0, mkKv(8'd6, 8'h66)};
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            logic took;
            cmd_valid = (idx < 6);
            cmd_op    = stallOp[idx < 6 ? idx : 5];
            cmd_kv    = stallKv[idx < 6 ? idx : 5];
            @(negedge clk);
            took = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (took) idx++;
        end
        @(negedge clk);
        checkOutput("stallAccepted", idx, 5);
        checkOutput("stallCmdReady", cmd_ready, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        applyStimulus(stallOp[5], stallKv[5]);
        waitDrain(100);

        // Busy device defers the strobe; reset in HOLD drops the response and the queued command.
        pq_busy = 1'b1;
        applyStimulus(OP_REPL, mkKv(8'd20, 8'hA0));
        applyStimulus(OP_DEQ, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("busyNoStrobe", {30'd0, pq_enq, pq_deq}, 0);
            checkOutput("busyNoRsp", rsp_valid, 0);
            @(posedge clk);
            #1;
        end
        pq_busy   = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("strobeAfterBusy", pq_enq, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rspAfterBusy", rsp_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rspDropOnRst", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("postRstStrobe", {30'd0, pq_enq, pq_deq}, 0);
            checkOutput("postRstRsp", rsp_valid, 0);
            checkOutput("postRstReady", cmd_ready, 1);
            @(posedge clk);
            #1;
        end

        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_kv    = mkKv(8'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            pq_busy   = ($urandom_range(0, 4) == 0);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        pq_busy   = 1'b0;
        rsp_ready = 1'b1;
        waitDrain(200);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
